// File: rtl/wb_register_file_if.sv
// rtl/wb_register_file_if.sv - MEM/WB write-back and ID read-port bundle for wb_register_file
interface wb_register_file_if;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [31:0] ALUResult_i;
  logic [31:0] Memdata_i;
  logic [4:0]  RDaddr_i;
  logic [4:0]  RS1addr_i;
  logic [4:0]  RS2addr_i;
  logic [31:0] RS1data_o;
  logic [31:0] RS2data_o;
  logic [31:0] WBdata_o;
  logic        WBen_o;
  logic [31:0] WBcount_o;

  modport master (
    output RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    output RDaddr_i, RS1addr_i, RS2addr_i,
    input  RS1data_o, RS2data_o, WBdata_o, WBen_o, WBcount_o
  );

  modport slave (
    input  RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    input  RDaddr_i, RS1addr_i, RS2addr_i,
    output RS1data_o, RS2data_o, WBdata_o, WBen_o, WBcount_o
  );
endinterface

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - write-back select, 32x32 register file with write-through bypass, commit counter
module wb_register_file (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_register_file_if.slave   bus
);

  logic [31:0] regs_q [32];
  logic [31:0] wbcount_q, wbcount_d;
  logic [31:0] wbdata;
  logic        wben;
  logic [31:0] rs1data, rs2data;

  assign wbdata = bus.MemtoReg_i ? bus.Memdata_i : bus.ALUResult_i;
  assign wben   = bus.RegWrite_i && (bus.RDaddr_i != 5'd0);

  assign wbcount_d = wben ? wbcount_q + 32'd1 : wbcount_q;

  // Entry 0 is never written, so it stays zero from reset onward.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wbcount_q <= '0;
    end else begin
      if (wben) begin
        regs_q[bus.RDaddr_i] <= wbdata;
      end
      wbcount_q <= wbcount_d;
    end
  end

  // x0 check comes first so a bypass can never leak a value onto x0.
  always_comb begin
    rs1data = '0;
    if (bus.RS1addr_i != 5'd0) begin
      if (wben && (bus.RS1addr_i == bus.RDaddr_i)) begin
        rs1data = wbdata;
      end else begin
        rs1data = regs_q[bus.RS1addr_i];
      end
    end
  end

  always_comb begin
    rs2data = '0;
    if (bus.RS2addr_i != 5'd0) begin
      if (wben && (bus.RS2addr_i == bus.RDaddr_i)) begin
        rs2data = wbdata;
      end else begin
        rs2data = regs_q[bus.RS2addr_i];
      end
    end
  end

  assign bus.RS1data_o = rs1data;
  assign bus.RS2data_o = rs2data;
  assign bus.WBdata_o  = wbdata;
  assign bus.WBen_o    = wben;
  assign bus.WBcount_o = wbcount_q;

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - directed self-checking bench for wb_register_file
module tb_wb_register_file;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_register_file_if bus ();

  wb_register_file dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.RegWrite_i  = 1'b0;
    bus.MemtoReg_i  = 1'b0;
    bus.ALUResult_i = '0;
    bus.Memdata_i   = '0;
    bus.RDaddr_i    = '0;
    bus.RS1addr_i   = 5'd5;
    bus.RS2addr_i   = 5'd0;
    #2;
    check("reset_count", bus.WBcount_o, 32'h0);
    check("reset_rs1", bus.RS1data_o, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // x5 = 0x12345678, bypass visible before the edge
    bus.RegWrite_i  = 1'b1;
    bus.ALUResult_i = 32'h1234_5678;
    bus.RDaddr_i    = 5'd5;
    #1;
    check("x5_bypass", bus.RS1data_o, 32'h1234_5678);
    check("x5_wben", {31'd0, bus.WBen_o}, 32'h1);
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    check("x5_stored", bus.RS1data_o, 32'h1234_5678);
    check("x5_count", bus.WBcount_o, 32'h1);

    // asynchronous reset mid-cycle, then a write presented under reset is lost
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rs1", bus.RS1data_o, 32'h0);
    check("async_rst_count", bus.WBcount_o, 32'h0);
    bus.RegWrite_i  = 1'b1;
    bus.RDaddr_i    = 5'd6;
    bus.ALUResult_i = 32'h0000_0066;
    tick();
    check("rst_hold_count", bus.WBcount_o, 32'h0);
    bus.RegWrite_i = 1'b0;
    rst = 1'b0;
    bus.RS1addr_i = 5'd6;
    #1;
    check("rst_lost_x6", bus.RS1data_o, 32'h0);

    // x7 = 0xDEADBEEF via ALU path while Memdata carries a decoy
    bus.RegWrite_i  = 1'b1;
    bus.MemtoReg_i  = 1'b0;
    bus.ALUResult_i = 32'hDEAD_BEEF;
    bus.Memdata_i   = 32'h1111_1111;
    bus.RDaddr_i    = 5'd7;
    #1;
    check("x7_wbdata", bus.WBdata_o, 32'hDEAD_BEEF);
    tick();
    bus.RegWrite_i = 1'b0;
    bus.RS2addr_i  = 5'd7;
    #1;
    check("x7_rs2", bus.RS2data_o, 32'hDEAD_BEEF);
    check("x7_count", bus.WBcount_o, 32'h1);

    // both ports bypass memory data for x3
    bus.RegWrite_i  = 1'b1;
    bus.MemtoReg_i  = 1'b1;
    bus.Memdata_i   = 32'hCAFE_0001;
    bus.ALUResult_i = 32'h0000_0BAD;
    bus.RDaddr_i    = 5'd3;
    bus.RS1addr_i   = 5'd3;
    bus.RS2addr_i   = 5'd3;
    #1;
    check("x3_byp_rs1", bus.RS1data_o, 32'hCAFE_0001);
    check("x3_byp_rs2", bus.RS2data_o, 32'hCAFE_0001);
    check("x3_wbdata", bus.WBdata_o, 32'hCAFE_0001);
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    check("x3_rs1", bus.RS1data_o, 32'hCAFE_0001);
    check("x3_rs2", bus.RS2data_o, 32'hCAFE_0001);
    check("x3_count", bus.WBcount_o, 32'h2);

    // x0 write is discarded and never bypassed
    bus.RegWrite_i  = 1'b1;
    bus.MemtoReg_i  = 1'b0;
    bus.ALUResult_i = 32'hFFFF_FFFF;
    bus.RDaddr_i    = 5'd0;
    bus.RS1addr_i   = 5'd0;
    bus.RS2addr_i   = 5'd0;
    #1;
    check("x0_rs1_pre", bus.RS1data_o, 32'h0);
    check("x0_wben", {31'd0, bus.WBen_o}, 32'h0);
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    check("x0_rs1_post", bus.RS1data_o, 32'h0);
    check("x0_count", bus.WBcount_o, 32'h2);

    // gated write: x9 holds its prior value, no bypass
    bus.RegWrite_i  = 1'b1;
    bus.ALUResult_i = 32'h0000_0099;
    bus.RDaddr_i    = 5'd9;
    tick();
    bus.RegWrite_i  = 1'b0;
    bus.ALUResult_i = 32'h0000_0055;
    bus.RS1addr_i   = 5'd9;
    #1;
    check("gated_rs1_pre", bus.RS1data_o, 32'h0000_0099);
    check("gated_wbdata", bus.WBdata_o, 32'h0000_0055);
    check("gated_wben", {31'd0, bus.WBen_o}, 32'h0);
    tick();
    check("gated_rs1_post", bus.RS1data_o, 32'h0000_0099);
    check("gated_count", bus.WBcount_o, 32'h3);

    // independent ports: one reads storage, the other bypasses
    bus.RegWrite_i  = 1'b1;
    bus.ALUResult_i = 32'h0000_0033;
    bus.RDaddr_i    = 5'd3;
    bus.RS1addr_i   = 5'd7;
    bus.RS2addr_i   = 5'd3;
    #1;
    check("indep_rs1", bus.RS1data_o, 32'hDEAD_BEEF);
    check("indep_rs2", bus.RS2data_o, 32'h0000_0033);
    tick();
    bus.RegWrite_i = 1'b0;
    #1;
    check("indep_count", bus.WBcount_o, 32'h4);

    // counter wrap from preloaded all-ones
    force dut.wbcount_q = 32'hFFFF_FFFF;
    #1;
    release dut.wbcount_q;
    #1;
    check("wrap_preload", bus.WBcount_o, 32'hFFFF_FFFF);
    bus.RegWrite_i  = 1'b1;
    bus.ALUResult_i = 32'h0000_00AA;
    bus.RDaddr_i    = 5'd10;
    tick();
    bus.RegWrite_i = 1'b0;
    bus.RS1addr_i  = 5'd10;
    #1;
    check("wrap_count", bus.WBcount_o, 32'h0);
    check("wrap_x10", bus.RS1data_o, 32'h0000_00AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
